// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sseg_pkg
// Description : Shared constants for the seven-segment scanner: the hex glyph
//               table (active-low {g,f,e,d,c,b,a}), the blank pattern and the
//               brightness field width.
// Revision    : 1.0 - initial release
// ============================================================================
package sseg_pkg;

    localparam int         BRIGHT_W  = 4;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n is the active-low glyph for hex digit n (lower-case b and d).
    // Listed from F down to 0 so that index 0 lands on the rightmost element.
    localparam logic [15:0][6:0] SEG_PATTERNS = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage
`default_nettype wire

// File: rtl/hex_to_sseg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_sseg
// Description : Combinational hex nibble to seven-segment decoder.
// Ports       : nib_i   [3:0] - hex value to display
//               seg_n_o [6:0] - active-low segments {g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_PATTERNS[nib_i];
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_mux
// Description : Time-multiplexed common-anode seven-segment scanner with a
//               per-frame input snapshot, digit enable mask, decimal points,
//               PWM brightness and a blank window at every digit change.
// Ports       : clk          - system clock
//               rst_n        - asynchronous active-low reset
//               data_i       - packed hex nibbles, nibble k drives digit k
//               dp_i         - decimal point per digit, 1 = lit
//               en_i         - digit enable, 0 = digit dark
//               bright_i     - brightness, 0 = off .. 15 = maximum
//               an_n         - anodes, active-low
//               seg_n        - segments {g,f,e,d,c,b,a}, active-low
//               dp_n         - decimal point, active-low
//               frame_start  - one-cycle pulse as a new snapshot takes effect
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_mux
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_W      = 16,
    parameter int BLANK_CYC  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   en_i,
    input  logic [BRIGHT_W-1:0]     bright_i,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int                    IDX_W   = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]      IDX_TOP = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0]      BLANK_C = DIV_W'(BLANK_CYC);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = '1;

    // Scan state
    logic [DIV_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    // Per-frame snapshot of the user inputs
    logic [4*NUM_DIGITS-1:0] data_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [NUM_DIGITS-1:0]   en_q;
    logic [BRIGHT_W-1:0]     bright_q;

    // Output registers
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic [6:0]              seg_n_q, seg_n_d;
    logic                    dp_n_q, dp_n_d;
    logic                    frame_start_q;

    logic                    cnt_max;
    logic                    boundary;
    logic                    lit;
    logic                    active;
    logic [3:0]              nib;
    logic [6:0]              seg_dec;

    assign cnt_max  = &cnt_q;
    assign boundary = cnt_max && (idx_q == '0);

    // The blank window at the start of every slot keeps adjacent anodes from
    // overlapping; the PWM compare uses the top nibble of the slot counter.
    assign lit    = (cnt_q >= BLANK_C) && (cnt_q[DIV_W-1 -: BRIGHT_W] < bright_q);
    assign active = lit && en_q[idx_q];
    assign nib    = data_q[{idx_q, 2'b00} +: 4];

    hex_to_sseg u_dec (
        .nib_i   (nib),
        .seg_n_o (seg_dec)
    );

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_max) begin
            idx_d = (idx_q == '0) ? IDX_TOP : idx_q - 1'b1;
        end
    end

    always_comb begin
        an_n_d  = AN_OFF;
        seg_n_d = SEG_BLANK;
        dp_n_d  = 1'b1;
        if (active) begin
            an_n_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_n_d = seg_dec;
            dp_n_d  = ~dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= IDX_TOP;
            data_q        <= '0;
            dp_q          <= '0;
            en_q          <= '0;
            bright_q      <= '0;
            an_n_q        <= AN_OFF;
            seg_n_q       <= SEG_BLANK;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            an_n_q        <= an_n_d;
            seg_n_q       <= seg_n_d;
            dp_n_q        <= dp_n_d;
            frame_start_q <= boundary;
            // Inputs are sampled only here so a frame never mixes old and new data.
            if (boundary) begin
                data_q   <= data_i;
                dp_q     <= dp_i;
                en_q     <= en_i;
                bright_q <= bright_i;
            end
        end
    end

    assign an_n        = an_n_q;
    assign seg_n       = seg_n_q;
    assign dp_n        = dp_n_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_mux
// Description : Scoreboard bench for seg_scan_mux (4 digits, 64-cycle slots,
//               2-cycle blank). Stimulus queues one expected summary per
//               digit slot; the monitor summarises each 64-cycle output
//               window and compares it against the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_mux;

    localparam int ND   = 4;
    localparam int DW   = 6;
    localparam int BC   = 2;
    localparam int SLOT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_i = 16'h0000;
    logic [3:0]  dp_i = 4'h0;
    logic [3:0]  en_i = 4'h0;
    logic [3:0]  bright_i = 4'h0;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_start;

    typedef struct {
        int         lit;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         fs;
    } slot_t;

    slot_t sb[$];
    int    checks   = 0;
    int    failures = 0;
    int    p        = 0;   // output cycles since reset release

    seg_scan_mux #(
        .NUM_DIGITS (ND),
        .DIV_W      (DW),
        .BLANK_CYC  (BC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_i      (data_i),
        .dp_i        (dp_i),
        .en_i        (en_i),
        .bright_i    (bright_i),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b0000011;
            4'hC:    glyph = 7'b1000110;
            4'hD:    glyph = 7'b0100001;
            default: glyph = 7'bxxxxxxx;
        endcase
    endfunction

    // Queue expectations for the first nslots slots of one frame (digit 3 first).
    task automatic push_frame(input int lit, input logic [3:0] en, input logic [15:0] d,
                              input logic [3:0] dp, input int nslots);
        slot_t s;
        int    ix;
        for (int k = 0; k < nslots; k++) begin
            ix    = 3 - k;
            s.lit = en[ix] ? lit : 0;
            s.an  = ~(4'b0001 << ix);
            s.seg = glyph(d[ix*4 +: 4]);
            s.dp  = ~dp[ix];
            s.fs  = (ix == 0) ? 1 : 0;
            sb.push_back(s);
        end
    endtask

    task automatic wait_p(input int t);
        int g;
        g = 0;
        while (p < t && g < 4000) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (p < t) chk("wait_timeout", p, t);
        #2;
    endtask

    // Monitor: summarise each slot-sized output window and compare.
    initial begin : mon
        int         o;
        int         slot;
        int         lit_n;
        int         fs_n;
        int         glitch;
        int         first_o;
        int         zeros;
        logic [3:0] an_s;
        logic [6:0] seg_s;
        logic       dp_s;
        slot_t      e;
        lit_n = 0; fs_n = 0; glitch = 0; first_o = 0;
        an_s = 4'hF; seg_s = 7'h7F; dp_s = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p      = 0;
                lit_n  = 0;
                fs_n   = 0;
                glitch = 0;
            end else begin
                p++;
                o    = ((p - 1) % SLOT) + 1;
                slot = (p - 1) / SLOT;
                if (o == 1) begin
                    lit_n = 0; fs_n = 0; glitch = 0; first_o = 0;
                end
                zeros = 0;
                for (int b = 0; b < 4; b++) if (!an_n[b]) zeros++;
                if (zeros > 1) glitch++;
                if (an_n != 4'hF) begin
                    if (lit_n == 0) begin
                        an_s = an_n; seg_s = seg_n; dp_s = dp_n; first_o = o;
                    end else if (an_n != an_s || seg_n != seg_s || dp_n != dp_s) begin
                        glitch++;
                    end
                    lit_n++;
                end else if (seg_n != 7'h7F || dp_n != 1'b1) begin
                    glitch++;
                end
                if (frame_start) fs_n++;
                if (o == SLOT) begin
                    if (sb.size() == 0) begin
                        chk($sformatf("slot%0d_sb_underflow", slot), 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("slot%0d_lit_cycles", slot), lit_n, e.lit);
                        chk($sformatf("slot%0d_frame_start", slot), fs_n, e.fs);
                        chk($sformatf("slot%0d_glitch", slot), glitch, 0);
                        if (e.lit > 0) begin
                            chk($sformatf("slot%0d_an_n", slot), int'(an_s), int'(e.an));
                            chk($sformatf("slot%0d_seg_n", slot), int'(seg_s), int'(e.seg));
                            chk($sformatf("slot%0d_dp_n", slot), int'(dp_s), int'(e.dp));
                            chk($sformatf("slot%0d_first_lit", slot), first_o, BC + 1);
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        // Reset state
        en_i     = 4'hF;
        data_i   = 16'h1234;
        dp_i     = 4'b0010;
        bright_i = 4'd15;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_an_n", int'(an_n), 'hF);
        chk("rst_seg_n", int'(seg_n), 'h7F);
        chk("rst_dp_n", int'(dp_n), 1);
        chk("rst_frame_start", int'(frame_start), 0);

        push_frame(0, 4'hF, 16'h1234, 4'b0010, 4);    // frame 0 dark
        push_frame(58, 4'hF, 16'h1234, 4'b0010, 4);   // full brightness
        #1;
        rst_n = 1'b1;

        wait_p(300);
        bright_i = 4'd8;
        push_frame(30, 4'hF, 16'h1234, 4'b0010, 4);   // half brightness

        wait_p(600);
        bright_i = 4'd0;
        push_frame(0, 4'hF, 16'h1234, 4'b0010, 4);    // off

        wait_p(850);
        bright_i = 4'd15;
        push_frame(58, 4'hF, 16'h1234, 4'b0010, 4);   // frame 4 keeps 1234

        wait_p(1100);                                 // inside digit 2 slot of frame 4
        data_i = 16'hABCD;
        push_frame(58, 4'hF, 16'hABCD, 4'b0010, 4);

        wait_p(1300);
        en_i = 4'b0101;
        push_frame(58, 4'b0101, 16'hABCD, 4'b0010, 4);

        wait_p(1600);
        en_i = 4'hF;
        push_frame(58, 4'hF, 16'hABCD, 4'b0010, 2);   // interrupted by reset

        wait_p(1940);                                 // digit 1 slot of frame 7
        chk("pre_rst_an_n", int'(an_n), 'b1101);
        chk("pre_rst_seg_n", int'(seg_n), 'h46);
        chk("pre_rst_dp_n", int'(dp_n), 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_an_n", int'(an_n), 'hF);
        chk("mid_rst_seg_n", int'(seg_n), 'h7F);
        chk("mid_rst_dp_n", int'(dp_n), 1);
        chk("mid_rst_sb_empty", sb.size(), 0);
        push_frame(0, 4'hF, 16'hABCD, 4'b0010, 4);
        push_frame(58, 4'hF, 16'hABCD, 4'b0010, 4);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;

        wait_p(512);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
